// File: rtl/game_pkg.sv
// Shared types and constants for the round engine: hint/state enums, LFSR seed/taps, digit limits.
package game_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        EQ   = 2'd3
    } hint_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        FAIL = 3'd3,
        DONE = 3'd4
    } engine_state_t;

    localparam logic [9:0] LFSR_SEED  = 10'h001;
    localparam logic [9:0] LFSR_TAPS  = 10'h240;   // x^10 + x^7 + 1
    localparam logic [9:0] LIMIT_1D   = 10'd10;
    localparam logic [9:0] LIMIT_2D   = 10'd100;
    localparam logic [9:0] LIMIT_3D   = 10'd1000;
    localparam logic [2:0] ROUND_LAST = 3'd4;

    function automatic logic [9:0] digit_candidate(input logic [1:0] md, input logic [9:0] lfsr);
        logic [9:0] c;
        case (md)
            2'd1:    c = {6'd0, lfsr[3:0]};
            2'd2:    c = {3'd0, lfsr[6:0]};
            2'd3:    c = lfsr;
            default: c = 10'd0;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] digit_limit(input logic [1:0] md);
        logic [9:0] l;
        case (md)
            2'd1:    l = LIMIT_1D;
            2'd2:    l = LIMIT_2D;
            2'd3:    l = LIMIT_3D;
            default: l = 10'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR; key3 reloads the seed synchronously.
module lfsr10
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       key3,
    output logic [9:0] lfsr
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[8:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (key3) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/round_engine.sv
// Round engine: secret draw, 1 Hz countdown, guess scoring, round/fail tracking.
// ROUND_ENGINE_REVEAL_EN exposes the latched secret on secret_dbg; otherwise it reads 0.
//
// state | meaning
// IDLE  | no game (Max_digit == 0), outputs frozen
// LOAD  | drawing a secret from the LFSR, retrying until it is in range
// PLAY  | round running: guesses scored, timer counting down
// FAIL  | out of guesses or time, outputs held
// DONE  | all rounds won, outputs held
module round_engine
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       key3,
    input  logic       tick_1hz,
    input  logic       guess_valid,
    input  logic [9:0] guess_value,
    input  logic [6:0] Max_timer,
    input  logic [2:0] Max_guess,
    input  logic [1:0] Max_digit,
    output logic [6:0] timer,
    output logic [2:0] guess,
    output logic [2:0] round,
    output logic [1:0] hint,
    output logic [9:0] secret_dbg
);

    engine_state_t state_q, state_d;
    logic [6:0]    timer_q, timer_d;
    logic [2:0]    guess_q, guess_d;
    logic [2:0]    round_q, round_d;
    hint_t         hint_q, hint_d;
    logic [9:0]    secret_q, secret_d;
    logic [1:0]    md_q, md_d;

    logic [9:0]    lfsr;
    logic [9:0]    candidate;
    logic [2:0]    guess_inc;
    logic [2:0]    round_inc;
    logic          ended;

    lfsr10 u_lfsr (
        .clk  (clk),
        .key3 (key3),
        .lfsr (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        guess_d   = guess_q;
        round_d   = round_q;
        hint_d    = hint_q;
        secret_d  = secret_q;
        md_d      = Max_digit;
        guess_inc = guess_q + 3'd1;
        round_inc = round_q + 3'd1;
        candidate = digit_candidate(md_q, lfsr);
        ended     = 1'b0;

        if (Max_digit != md_q) begin
            if (Max_digit == 2'd0) begin
                state_d = IDLE;
            end else begin
                state_d = LOAD;
                round_d = 3'd1;
                guess_d = 3'd0;
                hint_d  = NONE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (Max_digit != 2'd0) state_d = LOAD;
                end
                LOAD: begin
                    if (candidate < digit_limit(md_q)) begin
                        secret_d = candidate;
                        timer_d  = Max_timer;
                        guess_d  = 3'd0;
                        state_d  = PLAY;
                    end
                end
                PLAY: begin
                    if (guess_valid) begin
                        if (guess_value == secret_q) begin
                            hint_d  = EQ;
                            round_d = round_inc;
                            guess_d = 3'd0;
                            state_d = (round_inc == ROUND_LAST) ? DONE : LOAD;
                            ended   = 1'b1;
                        end else begin
                            hint_d = (guess_value < secret_q) ? LOW : HIGH;
                            if (guess_inc == Max_guess) begin
                                guess_d = Max_guess + 3'd1;
                                timer_d = 7'd0;
                                state_d = FAIL;
                                ended   = 1'b1;
                            end else begin
                                guess_d = guess_inc;
                            end
                        end
                    end
                    // a tick in the same cycle as a round-ending guess is dropped
                    if (tick_1hz && !ended && timer_q != 7'd0) begin
                        timer_d = timer_q - 7'd1;
                        if (timer_q == 7'd1) begin
                            guess_d = Max_guess + 3'd1;
                            state_d = FAIL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (key3) begin
            state_q  <= IDLE;
            timer_q  <= 7'd0;
            guess_q  <= 3'd0;
            round_q  <= 3'd1;
            hint_q   <= NONE;
            secret_q <= 10'd0;
            md_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            guess_q  <= guess_d;
            round_q  <= round_d;
            hint_q   <= hint_d;
            secret_q <= secret_d;
            md_q     <= md_d;
        end
    end

    assign timer = timer_q;
    assign guess = guess_q;
    assign round = round_q;
    assign hint  = hint_q;

`ifdef ROUND_ENGINE_REVEAL_EN
    assign secret_dbg = secret_q;
`else
    assign secret_dbg = 10'd0;
`endif

endmodule

// File: tb/tb_round_engine.sv
// Directed scoreboard bench for round_engine; secret predicted from an independent LFSR model.
module tb_round_engine;

    logic       clk;
    logic       key3;
    logic       tick_1hz;
    logic       guess_valid;
    logic [9:0] guess_value;
    logic [6:0] Max_timer;
    logic [2:0] Max_guess;
    logic [1:0] Max_digit;
    logic [6:0] timer;
    logic [2:0] guess;
    logic [2:0] round;
    logic [1:0] dut_hint;
    logic [9:0] secret_dbg;

    round_engine dut (
        .clk         (clk),
        .key3        (key3),
        .tick_1hz    (tick_1hz),
        .guess_valid (guess_valid),
        .guess_value (guess_value),
        .Max_timer   (Max_timer),
        .Max_guess   (Max_guess),
        .Max_digit   (Max_digit),
        .timer       (timer),
        .guess       (guess),
        .round       (round),
        .hint        (dut_hint),
        .secret_dbg  (secret_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference LFSR, x^10 + x^7 + 1, seed 1
    logic [9:0] m_lfsr;
    always @(posedge clk) begin
        if (key3) m_lfsr <= 10'h001;
        else      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    typedef struct packed {
        logic [6:0] t;
        logic [2:0] g;
        logic [2:0] r;
        logic [1:0] h;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [6:0] e_timer;
    logic [2:0] e_guess;
    logic [2:0] e_round;
    logic [1:0] e_hint;
    logic [9:0] exp_secret;
    logic [1:0] cur_md;
    logic [6:0] cur_mt;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push();
        sb.push_back('{t: e_timer, g: e_guess, r: e_round, h: e_hint});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        cmp({tag, "_sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({tag, "_timer"}, 32'(timer), 32'(e.t));
            cmp({tag, "_guess"}, 32'(guess), 32'(e.g));
            cmp({tag, "_round"}, 32'(round), 32'(e.r));
            cmp({tag, "_hint"},  32'(dut_hint), 32'(e.h));
        end
    endtask

    task automatic check_secret(input string tag);
`ifdef ROUND_ENGINE_REVEAL_EN
        cmp({tag, "_secret"}, 32'(secret_dbg), 32'(exp_secret));
`else
        cmp({tag, "_secret_tied"}, 32'(secret_dbg), 32'd0);
`endif
    endtask

    task automatic do_step(input logic gv, input logic [9:0] val, input logic tk, input string tag);
        guess_valid = gv;
        guess_value = val;
        tick_1hz    = tk;
        push();
        cyc();
        guess_valid = 1'b0;
        tick_1hz    = 1'b0;
        pop_check(tag);
    endtask

    task automatic apply_reset(input string tag);
        key3 = 1'b1;
        cyc();
        e_timer = 7'd0; e_guess = 3'd0; e_round = 3'd1; e_hint = 2'd0;
        exp_secret = 10'd0;
        push();
        pop_check(tag);
        cmp({tag, "_secret_rst"}, 32'(secret_dbg), 32'd0);
        key3 = 1'b0;
    endtask

    // called right after the edge that entered LOAD
    task automatic wait_play(input string tag);
        logic [9:0] mask;
        logic [9:0] lim;
        logic [9:0] cand;
        bit found;
        mask  = (cur_md == 2'd1) ? 10'h00F : (cur_md == 2'd2) ? 10'h07F : 10'h3FF;
        lim   = (cur_md == 2'd1) ? 10'd10 : (cur_md == 2'd2) ? 10'd100 : 10'd1000;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            cand = m_lfsr & mask;
            if (cand < lim) begin
                exp_secret = cand;
                found      = 1'b1;
            end
            cyc();
        end
        cmp({tag, "_load_bound"}, 32'(found), 32'd1);
        e_timer = cur_mt;
        e_guess = 3'd0;
        push();
        pop_check(tag);
        check_secret(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        key3 = 1'b1; tick_1hz = 1'b0; guess_valid = 1'b0; guess_value = 10'd0;
        Max_timer = 7'd0; Max_guess = 3'd0; Max_digit = 2'd0;
        cyc();
        apply_reset("reset");

        // first game: 1 digit, 30 s, 3 guesses
        Max_digit = 2'd1; Max_timer = 7'd30; Max_guess = 3'd3;
        cur_md = 2'd1; cur_mt = 7'd30;
        push();
        cyc();
        pop_check("enter_load");
        wait_play("play_r1");

        e_guess = 3'd1;
        e_hint  = (exp_secret > 10'd0) ? 2'd1 : 2'd2;
        do_step(1'b1, (exp_secret > 10'd0) ? exp_secret - 10'd1 : exp_secret + 10'd3, 1'b0, "guess_low");
        e_guess = 3'd2; e_hint = 2'd2;
        do_step(1'b1, exp_secret + 10'd1, 1'b0, "guess_high");
        e_guess = 3'd0; e_hint = 2'd3; e_round = 3'd2;
        do_step(1'b1, exp_secret, 1'b0, "guess_eq");
        wait_play("play_r2");

        // three wrong guesses exhaust the budget
        e_guess = 3'd1; e_hint = 2'd2;
        do_step(1'b1, exp_secret + 10'd1, 1'b0, "wrong1");
        e_guess = 3'd2;
        do_step(1'b1, exp_secret + 10'd1, 1'b0, "wrong2");
        e_guess = 3'd4; e_timer = 7'd0;
        do_step(1'b1, exp_secret + 10'd1, 1'b0, "wrong3_fail");
        do_step(1'b1, exp_secret, 1'b1, "fail_hold");
        do_step(1'b0, 10'd0, 1'b1, "fail_hold_tick");

        apply_reset("key3_after_fail");
        push();
        cyc();
        pop_check("restart_load");
        wait_play("play_restart");

        // timeout path
        for (int i = 1; i <= 30; i++) begin
            e_timer = e_timer - 7'd1;
            if (e_timer == 7'd0) e_guess = 3'd4;
            do_step(1'b0, 10'd0, 1'b1, $sformatf("tick%0d", i));
        end
        do_step(1'b1, exp_secret, 1'b0, "timeout_hold");

        apply_reset("key3_after_timeout");
        push();
        cyc();
        pop_check("restart_load2");
        wait_play("play_restart2");
        for (int i = 1; i <= 29; i++) begin
            e_timer = e_timer - 7'd1;
            do_step(1'b0, 10'd0, 1'b1, $sformatf("tickb%0d", i));
        end
        // correct guess wins over the final tick
        e_hint = 2'd3; e_round = 3'd2; e_guess = 3'd0;
        do_step(1'b1, exp_secret, 1'b1, "eq_with_last_tick");
        wait_play("play_r2b");

        e_round = 3'd3;
        do_step(1'b1, exp_secret, 1'b0, "win_r2");
        wait_play("play_r3");
        e_round = 3'd4;
        do_step(1'b1, exp_secret, 1'b0, "win_r3_done");
        do_step(1'b1, 10'd0, 1'b1, "done_hold");

        // difficulty change restarts the game
        Max_digit = 2'd2; Max_timer = 7'd60;
        cur_md = 2'd2; cur_mt = 7'd60;
        e_round = 3'd1; e_guess = 3'd0; e_hint = 2'd0;
        push();
        cyc();
        pop_check("md_change_load");
        wait_play("play_md2");

        e_guess = 3'd1; e_hint = 2'd2;
        do_step(1'b1, exp_secret + 10'd1, 1'b0, "md2_wrong");

        // Max_digit -> 0 overrides a same-cycle correct guess and tick
        Max_digit = 2'd0;
        do_step(1'b1, exp_secret, 1'b1, "md_zero_override");
        do_step(1'b1, exp_secret, 1'b1, "idle_ignore");
        do_step(1'b0, 10'd0, 1'b1, "idle_ignore_tick");
        check_secret("idle_secret");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
